// File: rtl/eta_adder_arbiter.sv
// eta_adder_arbiter: round-robin arbiter in front of one shared 8-bit
// error-tolerant (ETA) approximate adder. Each transaction returns the
// approximate sum, the exact sum and a mismatch flag. Saturating operation
// and error counters allow the adder's accuracy to be characterised.
module eta_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8:0]             res_sum,
  output logic [8:0]             res_exact,
  output logic [ID_W-1:0]        res_id,
  output logic                   res_err,
  input  logic                   clr_stats,
  output logic [15:0]            op_count,
  output logic [15:0]            err_count
);

  localparam int unsigned PW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q;
  logic [7:0]      a_q, b_q;

  logic            res_valid_q;
  logic [8:0]      res_sum_q, res_exact_q;
  logic [ID_W-1:0] res_id_q;
  logic            res_err_q;
  logic [15:0]     op_count_q, op_count_d;
  logic [15:0]     err_count_q, err_count_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [PW-1:0]   probe;

  logic [3:0]      eta_lo;
  logic            eta_c;
  logic [4:0]      eta_hi;
  logic [8:0]      eta_sum;
  logic [8:0]      exact_sum;
  logic            eta_err;

  // Round-robin search: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    probe     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      probe = {1'b0, rr_ptr_q} + PW'(off);
      if (probe >= PW'(NUM_REQ)) begin
        probe = probe - PW'(NUM_REQ);
      end
      if (!grant_vld && req_valid[probe[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = probe[ID_W-1:0];
      end
    end
  end

  // Accept strobe: only in IDLE, only for the granted requester, never in reset.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer advances past the granted requester, wrapping at NUM_REQ.
  always_comb begin
    if (32'(grant_idx) == NUM_REQ - 1) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // ETA adder: approximate low nibble (OR with XOR lsb), carry guessed from
  // bit 3 only, exact high nibble.
  always_comb begin
    eta_lo    = {a_q[3:1] | b_q[3:1], a_q[0] ^ b_q[0]};
    eta_c     = a_q[3] & b_q[3];
    eta_hi    = {1'b0, a_q[7:4]} + {1'b0, b_q[7:4]} + {4'b0000, eta_c};
    eta_sum   = {eta_hi, eta_lo};
    exact_sum = {1'b0, a_q} + {1'b0, b_q};
    eta_err   = (eta_sum != exact_sum);
  end

  // Saturating statistics; a clear in the same cycle overrides any increment.
  always_comb begin
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    if (state_q == CALC) begin
      if (op_count_q != '1) begin
        op_count_d = op_count_q + 16'd1;
      end
      if (eta_err && (err_count_q != '1)) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
    if (clr_stats) begin
      op_count_d  = '0;
      err_count_d = '0;
    end
  end

  // Control FSM with registered operands, results and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_exact_q <= '0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q      <= req_a[{grant_idx, 3'b000} +: 8];
            b_q      <= req_b[{grant_idx, 3'b000} +: 8];
            id_q     <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CALC;
          end
        end
        CALC: begin
          res_sum_q   <= eta_sum;
          res_exact_q <= exact_sum;
          res_id_q    <= id_q;
          res_err_q   <= eta_err;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_exact = res_exact_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule

// File: doc/eta_adder_arbiter.md
# eta_adder_arbiter

Shares one 8-bit error-tolerant (ETA) approximate adder between `NUM_REQ` requesters using round-robin arbitration. Each transaction returns the approximate 9-bit sum, the exact 9-bit sum and a mismatch flag. Saturating operation and error counters support accuracy characterisation. The block sits between operand producers and a single result consumer, with valid/ready handshakes on both sides.

## Interface
- `NUM_REQ`, 4: number of requesters; supported range 2..8.
- `ID_W`, 2: width of the requester ID; `NUM_REQ <= 2**ID_W`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ: per-requester operand valid.
- `req_ready`  out  NUM_REQ: per-requester accept; at most one bit high.
- `req_a`  in  8*NUM_REQ: operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*NUM_REQ: operand B; same packing as `req_a`.
- `res_valid`  out  1: result valid.
- `res_ready`  in  1: consumer accept.
- `res_sum`  out  9: ETA approximate sum.
- `res_exact`  out  9: exact sum a+b.
- `res_id`  out  ID_W: index of the requester that issued the operands.
- `res_err`  out  1: `res_sum != res_exact`.
- `clr_stats`  in  1: synchronous clear of both counters.
- `op_count`  out  16: completed operations; saturates at 0xFFFF.
- `err_count`  out  16: operations with `res_err=1`; saturates at 0xFFFF.

## Operation
- **ETA function.** Low nibble: bit0 = a0^b0; bits1..3 = ai|bi. Carry into the high nibble = a3&b3. High nibble: exact 4-bit ripple add of a[7:4]+b[7:4]+carry, giving 5 bits. `res_sum` = {high5, low4}.
- **FSM states:** IDLE, CALC, HOLD.
- **IDLE.**
  - If any `req_valid` is high, grant the first valid requester, searching upward from `rr_ptr` with wrap.
  - `req_ready[g]` is high combinationally, only in IDLE and only for the granted g.
  - At the edge: capture `req_a[g]`, `req_b[g]` and g. Set `rr_ptr = (g+1) mod NUM_REQ`. Go to CALC.
  - With no valid request, stay in IDLE.
- **CALC.**
  - Drive the adder and the exact adder from the captured operands.
  - At the edge: load `res_sum`, `res_exact`, `res_id` and `res_err`; set `res_valid=1`; go to HOLD.
  - Increment `op_count`, and also `err_count` if the error flag is set. Both saturate.
- **HOLD.**
  - `res_*` stay stable while `res_valid=1` and `res_ready=0`.
  - On `res_valid & res_ready`: clear `res_valid` and go to IDLE. Result registers keep their last value.
- **Counter clear.** `clr_stats` zeroes both counters at the next edge. If a clear coincides with an increment, the clear wins and the result is 0.
- **Requester behaviour.** `req_valid` held by a requester that is not granted is not dropped; it competes again in the next IDLE cycle.

## Timing
- **Reset values:** state IDLE, `rr_ptr=0`, `res_valid=0`, `res_sum=0`, `res_exact=0`, `res_id=0`, `res_err=0`, `op_count=0`, `err_count=0`.
- `req_ready` is forced to 0 while `rst=1`.
- **Latency:** accept at edge k; `res_valid` rises at edge k+1.
- **Throughput:** with `res_ready` tied high, the next accept is at edge k+3, so one operation per 3 cycles maximum.
- **Reset mid-operation:** reset in CALC or HOLD discards the pending result and suppresses its counter increment. Everything returns to reset values at that edge.
- **Single-grant guarantee:** `req_ready` is never high outside IDLE. No more than one `req_ready` bit is high in any cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req_valid=1`. Every `req_ready`, `res_valid` and counter stays 0. After release, requester 0 is granted first.
- **Single request:** requester 2 sends a=0x35, b=0x42. One cycle after the accept, `res_valid=1`, `res_sum=0x077`, `res_exact=0x077`, `res_err=0`, `res_id=2`, `op_count=1`, `err_count=0`.
- **Error cases:** a=0x0F, b=0x01 gives `res_sum=0x00E`, `res_exact=0x010`, `res_err=1`. a=0x88, b=0x88 gives `res_sum=0x118`, `res_exact=0x110`, `res_err=1`. After both, `err_count=2`.
- **Round robin:** all 4 requesters hold valid with `res_ready=1`. Grant order is 0,1,2,3,0,1, and each accept is exactly 3 cycles after the previous one.
- **Backpressure:** hold `res_ready=0` for 5 cycles in HOLD. `res_*` stay stable, no `req_ready` is asserted and the counters do not change. Raising `res_ready` returns the FSM to IDLE on the next edge.
- **Clear and reset collisions:**
  - Assert `clr_stats` in the same cycle as a CALC increment: both counters read 0 afterwards.
  - Assert `rst` during HOLD: `res_valid` drops, the counters reset, and the next grant starts from requester 0.
